// File: rtl/cypher_lock_multi.sv
// cypher_lock_multi
//   Parametrised digit-code lock. A DIGITS-long code (4-bit digits, 0-9) is
//   programmed in SET and checked in ENTER. Consecutive failures are counted.
//   Reaching MAX_TRIES failures starts a LOCKOUT of exactly LOCKOUT_CYCLES
//   cycles, after which the lock returns to ARMED. Entry supports backspace,
//   and the code can be re-keyed while the lock is open.
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   key_valid/key_digit one-cycle keypad strobe and value (A-F ignored)
//   set_btn, open_btn   start programming / start an unlock attempt
//   confirm_btn         commit entry (SET/ENTER) or relock (OPEN)
//   clear_btn           backspace one digit
//   entry_digits        display nibbles, MS nibble = first digit
//   entry_count         digits currently entered
//   locked, unlocked    LED outputs
//   fail_count          consecutive failed attempts
//   lockout             high for the whole LOCKOUT dwell
module cypher_lock_multi #(
  parameter int DIGITS         = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             key_valid,
  input  logic [3:0]                       key_digit,
  input  logic                             set_btn,
  input  logic                             open_btn,
  input  logic                             confirm_btn,
  input  logic                             clear_btn,
  output logic [4*DIGITS-1:0]              entry_digits,
  output logic [$clog2(DIGITS+1)-1:0]      entry_count,
  output logic                             locked,
  output logic                             unlocked,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count,
  output logic                             lockout
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES);

  typedef enum logic [2:0] {
    S_EMPTY   = 3'd0,
    S_SET     = 3'd1,
    S_ARMED   = 3'd2,
    S_ENTER   = 3'd3,
    S_OPEN    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t                     state_q, state_d;
  logic [DIGITS-1:0][3:0]     code_q, code_d;
  logic [DIGITS-1:0][3:0]     entry_q, entry_d;   // slot 0 = first digit typed
  logic [CW-1:0]              entry_count_q, entry_count_d;
  logic [FW-1:0]              fail_count_q, fail_count_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [4*DIGITS-1:0]        entry_digits_q, entry_digits_d;
  logic                       locked_q, locked_d;
  logic                       unlocked_q, unlocked_d;
  logic                       lockout_q, lockout_d;

  logic do_confirm, do_clear, do_key, do_cmd, full;

  // Display image for a given state/entry: typed digits, 'A' for blank slots.
  function automatic logic [4*DIGITS-1:0] render(input state_t st,
                                                 input logic [DIGITS-1:0][3:0] ent,
                                                 input logic [CW-1:0] cnt);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      case (st)
        S_SET, S_ENTER: begin
          if (i < int'(cnt)) r[4*(DIGITS-1-i) +: 4] = ent[i];
          else               r[4*(DIGITS-1-i) +: 4] = 4'hA;
        end
        S_LOCKOUT: r[4*(DIGITS-1-i) +: 4] = 4'hF;
        default:   r[4*(DIGITS-1-i) +: 4] = 4'h0;
      endcase
    end
    return r;
  endfunction

  // Next-state, code storage, entry buffer, failure counter and lockout timer.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    entry_d       = entry_q;
    entry_count_d = entry_count_q;
    fail_count_d  = fail_count_q;
    timer_d       = timer_q;

    // Only the highest-priority pulse of the cycle is considered at all.
    do_confirm = confirm_btn;
    do_clear   = !confirm_btn && clear_btn;
    do_key     = !confirm_btn && !clear_btn && key_valid;
    do_cmd     = !confirm_btn && !clear_btn && !key_valid;
    full       = (entry_count_q == CW'(DIGITS));

    case (state_q)
      S_EMPTY: begin
        if (do_cmd && set_btn) begin
          state_d       = S_SET;
          entry_d       = '0;
          entry_count_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_SET, S_ENTER: begin
        if (do_confirm) begin
          if (!full) begin
            state_d = state_q;
          end else if (state_q == S_SET) begin
            code_d  = entry_q;
            state_d = S_ARMED;
          end else if (entry_q == code_q) begin
            state_d      = S_OPEN;
            fail_count_d = '0;
          end else if (fail_count_q == FW'(MAX_TRIES - 1)) begin
            fail_count_d = fail_count_q + FW'(1);
            state_d      = S_LOCKOUT;
            timer_d      = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            fail_count_d = fail_count_q + FW'(1);
            state_d      = S_ARMED;
          end
        end else if (do_clear) begin
          if (entry_count_q != '0) begin
            entry_count_d = entry_count_q - CW'(1);
            for (int i = 0; i < DIGITS; i++) begin
              if (CW'(i) == entry_count_q - CW'(1)) entry_d[i] = 4'h0;
              else                                  entry_d[i] = entry_q[i];
            end
          end else begin
            entry_count_d = entry_count_q;
          end
        end else if (do_key) begin
          if (!full && (key_digit <= 4'd9)) begin
            entry_count_d = entry_count_q + CW'(1);
            for (int i = 0; i < DIGITS; i++) begin
              if (CW'(i) == entry_count_q) entry_d[i] = key_digit;
              else                         entry_d[i] = entry_q[i];
            end
          end else begin
            entry_count_d = entry_count_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_ARMED: begin
        if (do_cmd && open_btn) begin
          state_d       = S_ENTER;
          entry_d       = '0;
          entry_count_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_OPEN: begin
        if (do_confirm) begin
          state_d = S_ARMED;
        end else if (do_cmd && set_btn) begin
          state_d       = S_SET;
          entry_d       = '0;
          entry_count_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOCKOUT: begin
        // Timer loaded with LOCKOUT_CYCLES-1, so release happens on the
        // LOCKOUT_CYCLES-th cycle spent here.
        if (timer_q == '0) begin
          state_d      = S_ARMED;
          fail_count_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // Output images derived from next-state values so registered outputs line up with state.
  always_comb begin
    entry_digits_d = render(state_d, entry_d, entry_count_d);
    locked_d       = 1'b0;
    unlocked_d     = 1'b1;
    lockout_d      = 1'b0;
    case (state_d)
      S_EMPTY:   begin locked_d = 1'b0; unlocked_d = 1'b1; lockout_d = 1'b0; end
      S_SET:     begin locked_d = 1'b0; unlocked_d = 1'b0; lockout_d = 1'b0; end
      S_ARMED,
      S_ENTER:   begin locked_d = 1'b1; unlocked_d = 1'b0; lockout_d = 1'b0; end
      S_OPEN:    begin locked_d = 1'b1; unlocked_d = 1'b1; lockout_d = 1'b0; end
      S_LOCKOUT: begin locked_d = 1'b1; unlocked_d = 1'b0; lockout_d = 1'b1; end
      default:   begin locked_d = 1'b0; unlocked_d = 1'b1; lockout_d = 1'b0; end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_EMPTY;
      code_q         <= '0;
      entry_q        <= '0;
      entry_count_q  <= '0;
      fail_count_q   <= '0;
      timer_q        <= '0;
      entry_digits_q <= '0;
      locked_q       <= 1'b0;
      unlocked_q     <= 1'b1;
      lockout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      entry_q        <= entry_d;
      entry_count_q  <= entry_count_d;
      fail_count_q   <= fail_count_d;
      timer_q        <= timer_d;
      entry_digits_q <= entry_digits_d;
      locked_q       <= locked_d;
      unlocked_q     <= unlocked_d;
      lockout_q      <= lockout_d;
    end
  end

  assign entry_digits = entry_digits_q;
  assign entry_count  = entry_count_q;
  assign locked       = locked_q;
  assign unlocked     = unlocked_q;
  assign fail_count   = fail_count_q;
  assign lockout      = lockout_q;

endmodule

// File: tb/tb_cypher_lock_multi.sv
// tb_cypher_lock_multi
//   Bench for cypher_lock_multi (DIGITS=4, MAX_TRIES=3, LOCKOUT_CYCLES=16).
//   A queue-based behavioural model of the lock tracks what every output must
//   be; a compare process checks all outputs against it on each falling edge.
//   Directed sequences pin the model with literal expectations, then random
//   pulses exercise the same rules.
module tb_cypher_lock_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'h0;
  logic        set_btn = 1'b0;
  logic        open_btn = 1'b0;
  logic        confirm_btn = 1'b0;
  logic        clear_btn = 1'b0;
  logic [15:0] entry_digits;
  logic [2:0]  entry_count;
  logic        locked;
  logic        unlocked;
  logic [1:0]  fail_count;
  logic        lockout;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  // Behavioural model state
  string mode;
  int    ent[$];
  int    code[4];
  int    fails;
  int    tmr;

  cypher_lock_multi #(.DIGITS(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .set_btn(set_btn), .open_btn(open_btn), .confirm_btn(confirm_btn),
    .clear_btn(clear_btn), .entry_digits(entry_digits), .entry_count(entry_count),
    .locked(locked), .unlocked(unlocked), .fail_count(fail_count), .lockout(lockout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mode = "EMPTY";
    ent.delete();
    for (int i = 0; i < 4; i++) code[i] = 0;
    fails = 0;
    tmr = 0;
  endfunction

  function automatic bit collecting();
    return (mode == "SET") || (mode == "ENTER");
  endfunction

  // One clock edge of the lock, from the sampled pulses.
  function automatic void model_step();
    bit match;
    if (mode == "LOCKOUT") begin
      if (tmr == 0) begin mode = "ARMED"; fails = 0; end
      else tmr--;
      return;
    end
    if (confirm_btn) begin
      if (collecting() && ent.size() == 4) begin
        if (mode == "SET") begin
          for (int i = 0; i < 4; i++) code[i] = ent[i];
          mode = "ARMED";
        end else begin
          match = 1'b1;
          for (int i = 0; i < 4; i++) if (ent[i] != code[i]) match = 1'b0;
          if (match) begin
            mode = "OPEN"; fails = 0;
          end else begin
            fails++;
            if (fails == 3) begin mode = "LOCKOUT"; tmr = 15; end
            else mode = "ARMED";
          end
        end
      end else if (mode == "OPEN") begin
        mode = "ARMED";
      end
    end else if (clear_btn) begin
      if (collecting() && ent.size() > 0) void'(ent.pop_back());
    end else if (key_valid) begin
      if (collecting() && ent.size() < 4 && key_digit <= 4'd9) ent.push_back(int'(key_digit));
    end else if ((mode == "EMPTY" || mode == "OPEN") && set_btn) begin
      mode = "SET"; ent.delete();
    end else if (mode == "ARMED" && open_btn) begin
      mode = "ENTER"; ent.delete();
    end
  endfunction

  function automatic logic [15:0] exp_disp();
    logic [15:0] r;
    logic [3:0]  nib;
    r = 16'h0;
    for (int i = 0; i < 4; i++) begin
      if (collecting()) nib = (i < ent.size()) ? 4'(ent[i]) : 4'hA;
      else if (mode == "LOCKOUT") nib = 4'hF;
      else nib = 4'h0;
      r[15-4*i -: 4] = nib;
    end
    return r;
  endfunction

  function automatic logic [1:0] exp_leds();
    if (mode == "EMPTY") return 2'b01;
    if (mode == "SET")   return 2'b00;
    if (mode == "OPEN")  return 2'b11;
    return 2'b10;
  endfunction

  // Compare process: all outputs against the model, every falling edge.
  always @(negedge clk) begin
    if (run_cmp && rst_n) begin
      chk("entry_digits", 32'(entry_digits), 32'(exp_disp()));
      chk("entry_count",  32'(entry_count),  32'(ent.size()));
      chk("leds",         32'({locked, unlocked}), 32'(exp_leds()));
      chk("fail_count",   32'(fail_count),   32'(fails));
      chk("lockout",      32'(lockout),      32'(mode == "LOCKOUT"));
    end
  end

  task automatic cyc(input logic kv, input logic [3:0] kd, input logic sb,
                     input logic ob, input logic cb, input logic clb);
    key_valid = kv; key_digit = kd; set_btn = sb;
    open_btn = ob; confirm_btn = cb; clear_btn = clb;
    @(posedge clk);
    model_step();
    @(negedge clk);
    key_valid = 1'b0; key_digit = 4'h0; set_btn = 1'b0;
    open_btn = 1'b0; confirm_btn = 1'b0; clear_btn = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);  cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic p_set();     cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic p_open();    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic p_confirm(); cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic p_clear();   cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

  task automatic code4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digits"}, 32'(entry_digits), 32'h0);
    chk({tag, "_count"},  32'(entry_count),  32'h0);
    chk({tag, "_leds"},   32'({locked, unlocked}), 32'h1);
    chk({tag, "_fails"},  32'(fail_count),   32'h0);
    chk({tag, "_lockout"},32'(lockout),      32'h0);
  endtask

  // Assert reset between edges, check outputs clear immediately, then release.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n;
  int p;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    run_cmp = 1'b1;

    // Program 1234 and open with it.
    p_set(); code4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("set_disp", 32'(entry_digits), 32'h1234);
    p_confirm();
    chk("armed_leds", 32'({locked, unlocked}), 32'h2);
    p_open(); code4(4'd1, 4'd2, 4'd3, 4'd4); p_confirm();
    chk("open_leds", 32'({locked, unlocked}), 32'h3);
    chk("open_fails", 32'(fail_count), 32'h0);
    p_confirm();

    // Three wrong attempts -> lockout of exactly 16 cycles.
    p_open(); code4(4'd1, 4'd2, 4'd3, 4'd5); p_confirm();
    chk("fail1", 32'(fail_count), 32'h1);
    p_open(); code4(4'd1, 4'd2, 4'd3, 4'd5); p_confirm();
    chk("fail2", 32'(fail_count), 32'h2);
    p_open(); code4(4'd1, 4'd2, 4'd3, 4'd5); p_confirm();
    chk("fail3", 32'(fail_count), 32'h3);
    chk("lock_disp", 32'(entry_digits), 32'hFFFF);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (lockout) n++;
      else break;
    end
    chk("lock_dwell", 32'(n), 32'd16);
    chk("post_lock_fails", 32'(fail_count), 32'h0);
    chk("post_lock_leds", 32'({locked, unlocked, lockout}), 32'h4);

    // Backspace, ignored A-F key, short confirm, overflow key, confirm priority.
    p_open(); key(4'd5); key(4'd6); p_clear(); key(4'd7); key(4'hB); key(4'd8);
    chk("bs_disp", 32'(entry_digits), 32'h578A);
    chk("bs_count", 32'(entry_count), 32'h3);
    p_confirm();
    chk("short_confirm", 32'(entry_digits), 32'h578A);
    key(4'd9);
    chk("fill_disp", 32'(entry_digits), 32'h5789);
    key(4'd1);
    chk("fifth_key", 32'(entry_digits), 32'h5789);
    cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("confirm_prio", 32'(fail_count), 32'h1);
    chk("confirm_prio_leds", 32'({locked, unlocked}), 32'h2);

    // Re-key while open.
    p_open(); code4(4'd1, 4'd2, 4'd3, 4'd4); p_confirm();
    p_set(); code4(4'd9, 4'd9, 4'd0, 4'd0); p_confirm();
    chk("rekey_leds", 32'({locked, unlocked}), 32'h2);
    p_open(); code4(4'd1, 4'd2, 4'd3, 4'd4); p_confirm();
    chk("old_code_fails", 32'(fail_count), 32'h1);
    p_open(); code4(4'd9, 4'd9, 4'd0, 4'd0); p_confirm();
    chk("new_code_opens", 32'({locked, unlocked}), 32'h3);

    // Reset mid-ENTER and mid-LOCKOUT.
    p_confirm(); p_open(); key(4'd1); key(4'd2);
    mid_reset("rst_enter");
    p_set(); code4(4'd0, 4'd0, 4'd0, 4'd1); p_confirm();
    for (int t = 0; t < 3; t++) begin p_open(); code4(4'd7, 4'd7, 4'd7, 4'd7); p_confirm(); end
    repeat (4) cyc(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_lockout", 32'(lockout), 32'h1);
    mid_reset("rst_lockout");

    // Random pulses, small digit alphabet so codes sometimes match.
    for (int c = 0; c < 4000; c++) begin
      p = $urandom_range(0, 99);
      if (p < 25) begin
        p = $urandom_range(0, 99);
        key(4'((p < 90) ? $urandom_range(0, 1) : $urandom_range(2, 15)));
      end else if (p < 80) begin
        p = $urandom_range(0, 99);
        if      (p < 30) p_confirm();
        else if (p < 45) p_clear();
        else if (p < 60) p_set();
        else if (p < 90) p_open();
        else cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
